// File: rtl/uart_pkg.sv
// Shared constants and FSM encoding for the UART transmit scheduler.
package uart_pkg;

    localparam int UART_ADDR_W   = 3;
    localparam int UART_DATA_W   = 8;
    localparam int MSG_BYTES_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } sched_state_e;

    // Index width for n items, never below one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// UART transmit write port: address/data/strobe toward the UART, full back from it.
interface uart_tx_scheduler_if #(
    parameter int ADDR_W = 3
) ();
    import uart_pkg::*;

    logic [ADDR_W-1:0]      uart_address;
    logic [UART_DATA_W-1:0] uart_w_data;
    logic                   uart_we;
    logic                   uart_full;

    modport master (
        output uart_address,
        output uart_w_data,
        output uart_we,
        input  uart_full
    );

    modport slave (
        input  uart_address,
        input  uart_w_data,
        input  uart_we,
        output uart_full
    );

endinterface

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above rr_ptr, wrapping.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               any_req
);

    always_comb begin
        int  j;
        logic found;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        j         = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            j = (int'(rr_ptr) + i) % NUM_REQ;
            if (!found && req[j]) begin
                found     = 1'b1;
                grant[j]  = 1'b1;
                grant_idx = IDX_W'(j);
            end
        end
        any_req = |req;
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART write port between NUM_REQ message sources.
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int NUM_REQ   = 2,
    parameter int MSG_BYTES = MSG_BYTES_DEF,
    parameter int ADDR_W    = UART_ADDR_W
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_REQ-1:0]                req,
    input  logic [NUM_REQ*MSG_BYTES*8-1:0]    req_data,
    output logic [NUM_REQ-1:0]                ack,
    output logic                              busy,
    uart_tx_scheduler_if.master               uart
);

    localparam int MSG_W = MSG_BYTES * UART_DATA_W;
    localparam int IDX_W = idx_width(NUM_REQ);

    sched_state_e           state_q, state_d;
    logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]       gnt_q, gnt_d;
    logic [ADDR_W-1:0]      byte_idx_q, byte_idx_d;
    logic [MSG_W-1:0]       msg_q, msg_d;
    logic [NUM_REQ-1:0]     ack_q, ack_d;
    logic                   busy_q, busy_d;
    logic                   we_q, we_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [UART_DATA_W-1:0] wdata_q, wdata_d;

    logic [NUM_REQ-1:0]     grant;
    logic [IDX_W-1:0]       grant_idx;
    logic                   any_req;
    logic [UART_DATA_W-1:0] cur_byte;
    logic [IDX_W-1:0]       next_ptr;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req       (req),
        .rr_ptr    (rr_ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_req   (any_req)
    );

    always_comb begin
        cur_byte = '0;
        for (int k = 0; k < MSG_BYTES; k++) begin
            if (byte_idx_q == ADDR_W'(k)) begin
                cur_byte = msg_q[k*UART_DATA_W +: UART_DATA_W];
            end
        end
    end

    assign next_ptr = (gnt_q == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        gnt_d      = gnt_q;
        byte_idx_d = byte_idx_q;
        msg_d      = msg_q;
        ack_d      = '0;
        busy_d     = busy_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (grant_idx == IDX_W'(i)) begin
                            msg_d = req_data[i*MSG_W +: MSG_W];
                        end
                    end
                    gnt_d      = grant_idx;
                    ack_d      = grant;
                    busy_d     = 1'b1;
                    byte_idx_d = '0;
                    state_d    = SEND;
                end
            end
            SEND: begin
                // Full seen this cycle suppresses the strobe registered at the next edge.
                if (!uart.uart_full) begin
                    we_d       = 1'b1;
                    addr_d     = byte_idx_q;
                    wdata_d    = cur_byte;
                    byte_idx_d = byte_idx_q + 1'b1;
                    if (byte_idx_q == ADDR_W'(MSG_BYTES - 1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                busy_d   = 1'b0;
                rr_ptr_d = next_ptr;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            gnt_q      <= '0;
            byte_idx_q <= '0;
            msg_q      <= '0;
            ack_q      <= '0;
            busy_q     <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            gnt_q      <= gnt_d;
            byte_idx_q <= byte_idx_d;
            msg_q      <= msg_d;
            ack_q      <= ack_d;
            busy_q     <= busy_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
        end
    end

    assign ack               = ack_q;
    assign busy              = busy_q;
    assign uart.uart_we      = we_q;
    assign uart.uart_address = addr_q;
    assign uart.uart_w_data  = wdata_q;

endmodule
